// File: rtl/ctc_pkg.sv
// Shared constants and types for the CTC interrupt controller slice.
package ctc_pkg;
  localparam int CTC_NUM_CH = 4;

  localparam logic [7:0] OPC_ED    = 8'hED;
  localparam logic [7:0] OPC_RETI2 = 8'h4D;

  localparam logic VEC_LSB = 1'b0;

  typedef enum logic {
    RETI_IDLE   = 1'b0,
    RETI_GOT_ED = 1'b1
  } reti_state_e;
endpackage

// File: rtl/ctc_int_ctrl_if.sv
// Z80-facing bus and daisy-chain signals of the CTC interrupt controller.
interface ctc_int_ctrl_if #(parameter int DWID = 8);
  logic            m1_n;
  logic            iorq_n;
  logic            rd_n;
  logic [DWID-1:0] din;
  logic [DWID-1:0] dout;
  logic            oe_n;
  logic            iei;
  logic            ieo;
  logic            int_n;

  modport master (output m1_n, iorq_n, rd_n, din, iei,
                  input  dout, oe_n, ieo, int_n);
  modport slave  (input  m1_n, iorq_n, rd_n, din, iei,
                  output dout, oe_n, ieo, int_n);
endinterface

// File: rtl/ctc_reti_detect.sv
// Watches opcode fetches on the Z80 bus and pulses reti_pulse on ED 4D.
//   state       | meaning
//   RETI_IDLE   | waiting for an ED prefix byte
//   RETI_GOT_ED | last fetched byte was ED
module ctc_reti_detect
  import ctc_pkg::*;
#(
  parameter int DWID = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            m1_n,
  input  logic            rd_n,
  input  logic            iorq_n,
  input  logic [DWID-1:0] din,
  output logic            reti_pulse
);
  reti_state_e state_q, state_d;
  logic        fetch_q, fetch_d;
  logic        fetch_pulse;

  assign fetch_d     = !m1_n && !rd_n && iorq_n;
  assign fetch_pulse = fetch_d && !fetch_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RETI_IDLE;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    reti_pulse = 1'b0;
    if (fetch_pulse) begin
      case (state_q)
        RETI_IDLE:   state_d = (din == OPC_ED) ? RETI_GOT_ED : RETI_IDLE;
        RETI_GOT_ED: begin
          if (din == OPC_RETI2) begin
            reti_pulse = 1'b1;
            state_d    = RETI_IDLE;
          end else if (din == OPC_ED) begin
            state_d = RETI_GOT_ED;
          end else begin
            state_d = RETI_IDLE;
          end
        end
        default:     state_d = RETI_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ctc_int_ctrl.sv
// CTC interrupt controller: channel priority, daisy chain, vector drive, RETI retire.
module ctc_int_ctrl
  import ctc_pkg::*;
#(
  parameter int NUM_CH = CTC_NUM_CH,
  parameter int DWID   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  ctc_int_ctrl_if.slave     bus,
  input  logic [NUM_CH-1:0] ch_int_req,
  input  logic [NUM_CH-1:0] ch_sw_reset,
  input  logic              vec_we,
  input  logic [4:0]        vec_data
);
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] in_service_q, in_service_d;
  logic [4:0]        vec_base_q, vec_base_d;
  logic [DWID-1:0]   dout_q, dout_d;
  logic              oe_n_q, oe_n_d;
  logic              int_n_q, int_n_d;
  logic              inta_q, inta_d;
  logic              ack_pulse;
  logic              reti_pulse;
  logic              blocked;
  logic [NUM_CH-1:0] eligible;
  logic [2:0]        sel;

  // Returns {valid, index} of the lowest set bit.
  function automatic logic [2:0] pick_lowest(input logic [NUM_CH-1:0] elig);
    logic [2:0] r;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (elig[k]) r = {1'b1, 2'(k)};
    end
    return r;
  endfunction

  ctc_reti_detect #(.DWID(DWID)) u_reti (
    .clk        (clk),
    .reset_n    (reset_n),
    .m1_n       (bus.m1_n),
    .rd_n       (bus.rd_n),
    .iorq_n     (bus.iorq_n),
    .din        (bus.din),
    .reti_pulse (reti_pulse)
  );

  assign inta_d    = !bus.m1_n && !bus.iorq_n;
  assign ack_pulse = inta_d && !inta_q;

  // A channel is blocked by its own or any higher-priority in-service bit.
  always_comb begin
    blocked  = 1'b0;
    eligible = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      blocked     = blocked | in_service_q[k];
      eligible[k] = pending_q[k] & ~blocked;
    end
  end

  assign sel = pick_lowest(eligible);

  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    vec_base_d   = vec_we ? vec_data : vec_base_q;
    dout_d       = dout_q;
    oe_n_d       = oe_n_q;
    int_n_d      = !(bus.iei && sel[2]);

    if (reti_pulse && bus.iei) in_service_d = in_service_q & (in_service_q - 1'b1);

    if (ack_pulse && bus.iei && sel[2]) begin
      pending_d[sel[1:0]]    = 1'b0;
      in_service_d[sel[1:0]] = 1'b1;
      dout_d                 = {vec_base_q, sel[1:0], VEC_LSB};
      oe_n_d                 = 1'b0;
    end else if (!inta_d) begin
      dout_d = '0;
      oe_n_d = 1'b1;
    end

    // A new request beats a same-cycle acknowledge; software reset beats both.
    pending_d = (pending_d | ch_int_req) & ~ch_sw_reset;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q    <= '0;
      in_service_q <= '0;
      vec_base_q   <= '0;
      dout_q       <= '0;
      oe_n_q       <= 1'b1;
      int_n_q      <= 1'b1;
      inta_q       <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      vec_base_q   <= vec_base_d;
      dout_q       <= dout_d;
      oe_n_q       <= oe_n_d;
      int_n_q      <= int_n_d;
      inta_q       <= inta_d;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.oe_n  = oe_n_q;
  assign bus.int_n = int_n_q;
  assign bus.ieo   = bus.iei && !(|in_service_q) && !((|pending_q) && !bus.m1_n);
endmodule

// File: tb/tb_ctc_int_ctrl.sv
// Directed bench for ctc_int_ctrl: priority, daisy chain, vectors, RETI, resets.
module tb_ctc_int_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] ch_int_req;
  logic [3:0] ch_sw_reset;
  logic       vec_we;
  logic [4:0] vec_data;
  int         errors = 0;
  int         checks = 0;
  int         reti_cnt = 0;
  int         reti_base;

  ctc_int_ctrl_if #(.DWID(8)) bus ();

  ctc_int_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .ch_int_req  (ch_int_req),
    .ch_sw_reset (ch_sw_reset),
    .vec_we      (vec_we),
    .vec_data    (vec_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dut.u_reti.reti_pulse) reti_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_req(input logic [3:0] m);
    ch_int_req = m;
    tick();
    ch_int_req = 4'b0;
  endtask

  // Ack cycle: check the driven vector, then release and let outputs settle.
  task automatic ack(input string tag, input logic [7:0] vec);
    bus.m1_n   = 1'b0;
    bus.iorq_n = 1'b0;
    tick();
    chk({tag, "_dout"}, bus.dout, vec);
    chk({tag, "_oe_n"}, 8'(bus.oe_n), 8'd0);
    tick();
    chk({tag, "_dout_hold"}, bus.dout, vec);
    bus.m1_n   = 1'b1;
    bus.iorq_n = 1'b1;
    tick();
    chk({tag, "_release_oe"}, 8'(bus.oe_n), 8'd1);
    chk({tag, "_release_dout"}, bus.dout, 8'h00);
  endtask

  task automatic fetch(input logic [7:0] b);
    bus.m1_n = 1'b0;
    bus.rd_n = 1'b0;
    bus.din  = b;
    tick();
    bus.m1_n = 1'b1;
    bus.rd_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n     = 1'b0;
    ch_int_req  = 4'b0;
    ch_sw_reset = 4'b0;
    vec_we      = 1'b0;
    vec_data    = 5'b0;
    bus.m1_n    = 1'b1;
    bus.iorq_n  = 1'b1;
    bus.rd_n    = 1'b1;
    bus.din     = 8'h00;
    bus.iei     = 1'b1;
    tick();
    tick();
    chk("rst_int_n", 8'(bus.int_n), 8'd1);
    chk("rst_oe_n", 8'(bus.oe_n), 8'd1);
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_ieo", 8'(bus.ieo), 8'd1);
    chk("rst_pending", 8'(dut.pending_q), 8'h0);
    reset_n = 1'b1;
    tick();

    // Single request on channel 2, base A0
    vec_we = 1'b1; vec_data = 5'b10100;
    tick();
    vec_we = 1'b0;
    pulse_req(4'b0100);
    chk("single_pending", 8'(dut.pending_q), 8'h04);
    chk("single_int_t1", 8'(bus.int_n), 8'd1);
    tick();
    chk("single_int_t2", 8'(bus.int_n), 8'd0);
    ack("single", 8'hA4);
    chk("single_in_service", 8'(dut.in_service_q), 8'h04);
    chk("single_int_after", 8'(bus.int_n), 8'd1);
    chk("single_ieo", 8'(bus.ieo), 8'd0);
    fetch(8'hED);
    fetch(8'h4D);
    chk("single_reti", 8'(dut.in_service_q), 8'h00);

    // Priority and nesting: channels 1 and 3 together
    pulse_req(4'b1010);
    tick();
    chk("prio_int", 8'(bus.int_n), 8'd0);
    ack("prio_ch1", 8'hA2);
    chk("prio_blocked", 8'(bus.int_n), 8'd1);
    fetch(8'hED);
    chk("prio_still_blocked", 8'(bus.int_n), 8'd1);
    fetch(8'h4D);
    chk("prio_int_again", 8'(bus.int_n), 8'd0);
    ack("prio_ch3", 8'hA6);
    chk("prio_in_service", 8'(dut.in_service_q), 8'h08);
    fetch(8'hED);
    fetch(8'h4D);
    chk("prio_cleared", 8'(dut.in_service_q), 8'h00);

    // Higher priority preempts channel 2 in service
    pulse_req(4'b0100);
    tick();
    ack("pre_ch2", 8'hA4);
    pulse_req(4'b0001);
    tick();
    chk("pre_int", 8'(bus.int_n), 8'd0);
    ack("pre_ch0", 8'hA0);
    chk("pre_in_service", 8'(dut.in_service_q), 8'h05);
    fetch(8'hED);
    fetch(8'h4D);
    chk("pre_reti_ch0", 8'(dut.in_service_q), 8'h04);
    fetch(8'hED);
    fetch(8'h4D);
    chk("pre_reti_ch2", 8'(dut.in_service_q), 8'h00);

    // Daisy chain disabled
    bus.iei = 1'b0;
    pulse_req(4'b0001);
    tick();
    chk("daisy_int", 8'(bus.int_n), 8'd1);
    chk("daisy_ieo", 8'(bus.ieo), 8'd0);
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
    tick();
    tick();
    chk("daisy_no_oe", 8'(bus.oe_n), 8'd1);
    chk("daisy_no_dout", bus.dout, 8'h00);
    chk("daisy_pending", 8'(dut.pending_q), 8'h01);
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    tick();
    bus.iei = 1'b1;
    tick();
    chk("daisy_int_on", 8'(bus.int_n), 8'd0);
    ack("daisy_ch0", 8'hA0);

    // RETI ignored with iei low
    bus.iei = 1'b0;
    fetch(8'hED);
    fetch(8'h4D);
    chk("reti_iei0", 8'(dut.in_service_q), 8'h01);
    bus.iei = 1'b1;
    fetch(8'hED);
    fetch(8'h4D);
    chk("reti_iei1", 8'(dut.in_service_q), 8'h00);

    // RETI decoding sequences
    reti_base = reti_cnt;
    fetch(8'hED);
    fetch(8'hED);
    fetch(8'h4D);
    chk("reti_ed_ed_4d", 8'(reti_cnt - reti_base), 8'd1);
    reti_base = reti_cnt;
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    chk("reti_ed_00_4d", 8'(reti_cnt - reti_base), 8'd0);

    // Same-cycle request+ack on channel 2 and vector write during ack
    pulse_req(4'b0100);
    tick();
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
    ch_int_req = 4'b0100;
    vec_we = 1'b1; vec_data = 5'b00001;
    tick();
    ch_int_req = 4'b0;
    vec_we = 1'b0;
    chk("same_dout_old_base", bus.dout, 8'hA4);
    chk("same_pending", 8'(dut.pending_q), 8'h04);
    chk("same_in_service", 8'(dut.in_service_q), 8'h04);
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    tick();
    fetch(8'hED);
    fetch(8'h4D);
    chk("same_int_again", 8'(bus.int_n), 8'd0);
    ack("same_new_base", 8'h0C);
    fetch(8'hED);
    fetch(8'h4D);

    // Software reset on channel 1
    pulse_req(4'b0010);
    tick();
    chk("swr_int", 8'(bus.int_n), 8'd0);
    ch_sw_reset = 4'b0010;
    tick();
    chk("swr_pending", 8'(dut.pending_q), 8'h00);
    tick();
    chk("swr_int_high", 8'(bus.int_n), 8'd1);
    ch_sw_reset = 4'b0;

    // Async reset in the middle of an acknowledge
    pulse_req(4'b0001);
    tick();
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
    tick();
    chk("arst_pre_oe", 8'(bus.oe_n), 8'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_oe_n", 8'(bus.oe_n), 8'd1);
    chk("arst_dout", bus.dout, 8'h00);
    chk("arst_in_service", 8'(dut.in_service_q), 8'h00);
    chk("arst_pending", 8'(dut.pending_q), 8'h00);
    chk("arst_vec_base", 8'(dut.vec_base_q), 8'h00);
    chk("arst_int_n", 8'(bus.int_n), 8'd1);
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ctc_int_ctrl.md
Name: ctc_int_ctrl

Overview:
- Interrupt controller for a 4-channel Z80 CTC.
- Collects zero-count interrupt requests from the four counter/timer channel cores and prioritises them (channel 0 highest).
- Takes part in the Z80 IEI/IEO daisy chain, drives INT_n, and returns the vector {base[7:3], channel[1:0], 0} in the interrupt-acknowledge cycle.
- Decodes RETI (ED 4D) from opcode fetches to retire the in-service channel.
- Sits in the CTC top level, between the four channel cores and the Z80 bus.

Parameters:
- NUM_CH, 4, number of channels; fixed at 4 because the vector encodes 2 channel bits.
- DWID, 8, data bus width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- m1_n  in  1  Z80 M1, already synchronous to clk.
- iorq_n  in  1  Z80 IORQ.
- rd_n  in  1  Z80 RD.
- din  in  DWID  Z80 data bus, input side.
- dout  out  DWID  vector output; zero when not driving.
- oe_n  out  1  output enable for dout, active-low.
- iei  in  1  daisy-chain enable in.
- ieo  out  1  daisy-chain enable out.
- int_n  out  1  interrupt request to CPU, active-low.
- ch_int_req  in  NUM_CH  single-cycle zero-count pulse per channel; interrupt-enable gating is already applied by the channel.
- ch_sw_reset  in  NUM_CH  level; channel is in software reset.
- vec_we  in  1  single-cycle strobe from channel 0: vector word written.
- vec_data  in  5  vector bits [7:3], captured on vec_we.

Behaviour:
- Reset values: pending=0, in_service=0, vec_base=0, dout=0, oe_n=1, int_n=1, RETI FSM=IDLE. ieo follows iei combinationally.
- Per-channel state:
  - pending[k] is set by ch_int_req[k]. It is cleared by acknowledge of k, and forced to 0 while ch_sw_reset[k]=1.
  - A request arriving while pending[k]=1 is absorbed (no count).
  - in_service[k] is set by acknowledge of k and cleared by RETI. ch_sw_reset does not affect it.
- Eligibility: channel k is eligible when pending[k]=1 and in_service[j]=0 for all j<=k.
- int_n is registered. Each cycle, int_n <= !(iei && any eligible).
  - Latency: ch_int_req pulse at cycle t, pending at t+1, int_n low at t+2.
- ieo is combinational: iei && !(|in_service) && !(|pending && !m1_n).
  - Pending during M1 freezes the chain below.
- Acknowledge:
  - inta = !m1_n && !iorq_n; ack_pulse = rising edge of the registered inta.
  - On ack_pulse with iei=1 and an eligible channel, k = lowest eligible index. Then clear pending[k], set in_service[k], dout <= {vec_base, k[1:0], 1'b0}, oe_n <= 0.
  - dout/oe_n hold while inta remains asserted, and return to 0/1 the cycle after inta deasserts.
  - ack_pulse with iei=0 or no eligible channel: no drive, no state change.
- Same-cycle events:
  - ch_int_req[k] in the same cycle as ack of k: the request wins, so pending[k] stays 1 and in_service[k] is set.
  - vec_we in the same cycle as ack: the old vec_base is used.
- RETI detection (sub-module):
  - fetch = !m1_n && !rd_n && iorq_n; fetch_pulse = rising edge. din is sampled in the fetch_pulse cycle.
  - FSM states IDLE and GOT_ED.
    - IDLE: din==8'hED goes to GOT_ED; any other byte stays IDLE.
    - GOT_ED: 8'h4D emits reti_pulse and goes to IDLE; 8'hED stays GOT_ED; any other byte goes to IDLE.
  - Non-fetch cycles between fetches do not disturb the state.
- RETI action: on reti_pulse with iei=1, clear the lowest-index set bit of in_service. With iei=0 or in_service=0, no effect.
- Reset mid-operation: all state and outputs return to reset values asynchronously. An acknowledge in progress releases oe_n immediately.

Decomposition:
- Package ctc_pkg holds:
  - CTC_NUM_CH=4.
  - OPC_ED=8'hED and OPC_RETI2=8'h4D.
  - RETI FSM state encoding (IDLE=1'b0, GOT_ED=1'b1).
  - Vector LSB constant 1'b0.
- Sub-module ctc_reti_detect:
  - Inputs: clk, reset_n, m1_n, rd_n, iorq_n, din.
  - Output: reti_pulse.
  - Contains the fetch edge detect and the FSM.
- The priority select is a function inside ctc_int_ctrl.

Test Plan:
- Single request:
  - Stimulus: vec_we with vec_data=5'b10100, then ch_int_req=4'b0100, then an ack cycle (m1_n=0, iorq_n=0).
  - Required: int_n low 2 cycles after the request; dout=8'hA4 with oe_n=0; in_service=4'b0100; int_n high after ack; ieo=0.
- Priority and nesting:
  - Stimulus: ch_int_req=4'b1010 in the same cycle, then ack.
  - Required: first vector selects channel 1 (dout=base|8'h02). int_n is low again only after RETI (fetch ED, fetch 4D) clears channel 1; second ack gives channel 3 (base|8'h06).
- Higher priority preempts:
  - Stimulus: channel 2 in service, then ch_int_req[0].
  - Required: int_n goes low; ack returns channel 0. RETI clears channel 0 first and in_service returns to 4'b0100.
- Daisy chain:
  - Stimulus: iei=0 with pending[0]=1.
  - Required: int_n=1, ack produces no drive, ieo=0. When iei goes to 1, int_n goes low 1 cycle later.
- RETI decoding:
  - Stimulus: fetch sequence ED ED 4D.
  - Required: exactly one reti_pulse.
  - Stimulus: sequence ED 00 4D.
  - Required: no pulse.
  - Stimulus: ED 4D with iei=0.
  - Required: in_service unchanged.
- Software reset and async reset:
  - Stimulus: ch_sw_reset[1]=1 while pending[1]=1.
  - Required: pending cleared and int_n returns high.
  - Stimulus: reset_n=0 during ack.
  - Required: oe_n=1 and dout=0 immediately, all state zero.
